// File: rtl/rv32_pipe_pkg.sv
// rv32_pipe_pkg
//   Shared definitions for the RV32 pipeline stage registers: the NOP
//   encoding that fills empty stages, the payload width of every stage
//   boundary, the bit offsets used to pack/unpack each boundary's payload,
//   and small helpers for the IF/ID boundary and for entry counting.
package rv32_pipe_pkg;

   // addi x0, x0, 0 : the canonical RV32 NOP placed in the instr field of a bubble
   localparam logic [31:0] OP_NOP = 32'h0000_0013;

   localparam int XLEN = 32;

   // ---------------------------------------------------------------- IF/ID
   localparam int IFID_PC_LSB      = 0;
   localparam int IFID_INSTR_LSB   = 32;
   localparam int IFID_PC_NEXT_LSB = 64;
   localparam int IFID_W           = 96;

   // Packed view of the IF/ID payload; field order matches the offsets above
   typedef struct packed {
      logic [31:0] pc_next;
      logic [31:0] instr;
      logic [31:0] pc;
   } ifid_t;

   localparam logic [IFID_W-1:0] IFID_BUBBLE = {32'h0000_0000, OP_NOP, 32'h0000_0000};

   // ---------------------------------------------------------------- ID/EX
   localparam int IDEX_PC_LSB     = 0;
   localparam int IDEX_RS1_LSB    = 32;
   localparam int IDEX_RS2_LSB    = 64;
   localparam int IDEX_IMM_LSB    = 96;
   localparam int IDEX_RD_LSB     = 128;  // 5 bits
   localparam int IDEX_ALU_OP_LSB = 133;  // 4 bits
   localparam int IDEX_CTRL_LSB   = 137;  // 8 bits
   localparam int IDEX_W          = 145;

   // ---------------------------------------------------------------- EX/MEM
   localparam int EXMEM_ALU_LSB   = 0;
   localparam int EXMEM_STORE_LSB = 32;
   localparam int EXMEM_RD_LSB    = 64;   // 5 bits
   localparam int EXMEM_CTRL_LSB  = 69;   // 8 bits
   localparam int EXMEM_W         = 77;

   // ---------------------------------------------------------------- MEM/WB
   localparam int MEMWB_DATA_LSB  = 0;
   localparam int MEMWB_RD_LSB    = 32;   // 5 bits
   localparam int MEMWB_CTRL_LSB  = 37;   // 8 bits
   localparam int MEMWB_W         = 45;

   // Entry occupancy as reported on occ_o
   typedef logic [1:0] occ_t;

   function automatic occ_t occ_count(input logic main_v, input logic skid_v);
      return occ_t'(main_v) + occ_t'(skid_v);
   endfunction

   function automatic logic [IFID_W-1:0] ifid_pack(input logic [31:0] pc,
                                                   input logic [31:0] instr,
                                                   input logic [31:0] pc_next);
      ifid_t p;
      p.pc      = pc;
      p.instr   = instr;
      p.pc_next = pc_next;
      return p;
   endfunction

   function automatic logic [31:0] ifid_pc(input logic [IFID_W-1:0] d);
      return d[IFID_PC_LSB +: 32];
   endfunction

   function automatic logic [31:0] ifid_instr(input logic [IFID_W-1:0] d);
      return d[IFID_INSTR_LSB +: 32];
   endfunction

   function automatic logic [31:0] ifid_pc_next(input logic [IFID_W-1:0] d);
      return d[IFID_PC_NEXT_LSB +: 32];
   endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// pipe_skid_entry
//   One valid + payload register. Used for the main entry of every stage
//   register and for the optional skid entry.
//   Ports:
//     clk_i   in   clock
//     rst_i   in   synchronous active-high reset -> empty, payload = BUBBLE
//     clr_i   in   empty the entry next cycle (payload = BUBBLE); beats load_i
//     ld_i    in   capture d_i and mark valid
//     d_i     in   DATA_W payload to capture
//     valid_o out  entry holds a beat
//     data_o  out  held payload, BUBBLE while empty
module pipe_skid_entry
   import rv32_pipe_pkg::*;
#(
   parameter int                DATA_W = 96,
   parameter logic [DATA_W-1:0] BUBBLE = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              ld_i,
   input  logic [DATA_W-1:0] d_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
);

   logic              valid_d, valid_q;
   logic [DATA_W-1:0] data_d,  data_q;

   // Clear wins over load so a flush can never leave a beat behind
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clr_i) begin
         valid_d = 1'b0;
         data_d  = BUBBLE;
      end else if (ld_i) begin
         valid_d = 1'b1;
         data_d  = d_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= BUBBLE;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic pipeline stage register with valid/ready handshake,
//   flush-to-bubble and an optional two-entry skid mode.
//
//   Handshake: a beat moves when valid and ready are both 1 at a rising
//   edge. valid never depends on ready; out_data_o is stable while
//   out_valid_o = 1 and out_ready_i = 0. In skid mode in_ready_o comes
//   straight from a flop, so the upstream ready path is fully registered.
//
//   Ports:
//     clk_i        in   clock
//     rst_i        in   synchronous active-high reset (same effect as flush)
//     flush_i      in   drop every held and incoming beat
//     in_valid_i   in   upstream beat present
//     in_ready_o   out  stage can accept
//     in_data_i    in   DATA_W upstream payload
//     out_valid_o  out  downstream beat present
//     out_ready_i  in   downstream accepts
//     out_data_o   out  DATA_W payload, BUBBLE while out_valid_o = 0
//     occ_o        out  entries held (0..2)
module pipe_stage_reg
   import rv32_pipe_pkg::*;
#(
   parameter int                DATA_W  = 96,
   parameter logic [DATA_W-1:0] BUBBLE  = {DATA_W{1'b0}},
   parameter bit                SKID_EN = 1'b0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occ_o
);

   logic              main_v;
   logic [DATA_W-1:0] main_data;
   logic              main_ld;
   logic              main_clr;
   logic [DATA_W-1:0] main_din;
   logic              skid_v;
   logic              in_hs;
   logic              out_hs;

   assign in_hs  = in_valid_i & in_ready_o;
   assign out_hs = main_v & out_ready_i;

   pipe_skid_entry #(
      .DATA_W (DATA_W),
      .BUBBLE (BUBBLE)
   ) u_main (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (main_clr),
      .ld_i    (main_ld),
      .d_i     (main_din),
      .valid_o (main_v),
      .data_o  (main_data)
   );

   if (SKID_EN) begin : g_skid
      logic              skid_ld;
      logic              skid_clr;
      logic [DATA_W-1:0] skid_data;
      logic              skid_v_next;
      logic              in_ready_d, in_ready_q;

      pipe_skid_entry #(
         .DATA_W (DATA_W),
         .BUBBLE (BUBBLE)
      ) u_skid (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .clr_i   (skid_clr),
         .ld_i    (skid_ld),
         .d_i     (in_data_i),
         .valid_o (skid_v),
         .data_o  (skid_data)
      );

      // Steering. Skid only ever holds the beat that arrived after main's,
      // so whenever main drains with skid full, skid moves up first and a
      // simultaneous new beat refills skid: arrival order is preserved.
      always_comb begin
         main_ld  = 1'b0;
         main_clr = flush_i;
         main_din = in_data_i;
         skid_ld  = 1'b0;
         skid_clr = flush_i;
         if (skid_v) begin
            main_din = skid_data;
            if (out_hs) begin
               main_ld  = 1'b1;
               skid_ld  = in_hs;
               skid_clr = skid_clr | ~in_hs;
            end
         end else begin
            if (in_hs && (!main_v || out_hs)) begin
               main_ld = 1'b1;
            end else if (in_hs) begin
               skid_ld = 1'b1;
            end else if (out_hs) begin
               main_clr = 1'b1;
            end
         end
      end

      // Next-cycle skid occupancy, mirrored into the ready flop
      always_comb begin
         skid_v_next = skid_v;
         if (skid_clr) begin
            skid_v_next = 1'b0;
         end else if (skid_ld) begin
            skid_v_next = 1'b1;
         end
         in_ready_d = ~skid_v_next;
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            in_ready_q <= 1'b1;
         end else begin
            in_ready_q <= in_ready_d;
         end
      end

      assign in_ready_o = in_ready_q;
   end else begin : g_single
      assign skid_v     = 1'b0;
      assign in_ready_o = ~main_v | out_ready_i;

      always_comb begin
         main_din = in_data_i;
         main_ld  = in_hs;
         main_clr = flush_i | (out_hs & ~in_hs);
      end
   end

   assign out_valid_o = main_v;
   // main holds BUBBLE whenever it is empty, so no output mux is needed
   assign out_data_o  = main_data;
   assign occ_o       = occ_count(main_v, skid_v);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Drives one single-entry and one skid-mode stage register with the same
//   upstream/downstream stimulus. A queue model per instance tracks which
//   beats are held, in arrival order, and is compared every cycle; directed
//   literal checks pin the model at the interesting points.
module tb_pipe_stage_reg;
   import rv32_pipe_pkg::*;

   localparam int W = IFID_W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b1;
   logic [W-1:0]  in_data = '0;
   logic          out_ready = 1'b0;

   logic          in_ready0, out_valid0, in_ready1, out_valid1;
   logic [W-1:0]  out_data0, out_data1;
   logic [1:0]    occ0, occ1;

   int            errors = 0;
   int            checks = 0;
   bit            chk_en = 1'b0;

   // model state: beats held, oldest first
   logic [W-1:0]  exp_q0[$];
   logic [W-1:0]  exp_q1[$];
   int            cons0 = 0, cons1 = 0;          // model handshakes on out_*
   int            dut_cons0 = 0, dut_cons1 = 0;  // observed handshakes on out_*

   // ---------------------------------------------------------------- clock/reset
   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(W), .BUBBLE(IFID_BUBBLE), .SKID_EN(1'b0)) u_dut0 (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready0),
      .in_data_i   (in_data),
      .out_valid_o (out_valid0),
      .out_ready_i (out_ready),
      .out_data_o  (out_data0),
      .occ_o       (occ0)
   );

   pipe_stage_reg #(.DATA_W(W), .BUBBLE(IFID_BUBBLE), .SKID_EN(1'b1)) u_dut1 (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready1),
      .in_data_i   (in_data),
      .out_valid_o (out_valid1),
      .out_ready_i (out_ready),
      .out_data_o  (out_data1),
      .occ_o       (occ1)
   );

   // ---------------------------------------------------------------- helpers
   function automatic logic [W-1:0] mk(input logic [31:0] pc);
      return ifid_pack(pc, 32'h0010_0093 ^ pc, pc + 32'd4);
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   // ---------------------------------------------------------------- model
   // Capacity 1 (ready when empty or downstream ready) or capacity 2
   // (ready while fewer than two beats held). Reset/flush empties it.
   always @(posedge clk) begin
      bit ir0, ir1, ihs0, ihs1, ohs0, ohs1;
      ir0  = (exp_q0.size() == 0) || out_ready;
      ir1  = exp_q1.size() < 2;
      ihs0 = in_valid && ir0;
      ihs1 = in_valid && ir1;
      ohs0 = (exp_q0.size() != 0) && out_ready;
      ohs1 = (exp_q1.size() != 0) && out_ready;
      if (ohs0) cons0++;
      if (ohs1) cons1++;
      if (rst || flush) begin
         exp_q0.delete();
         exp_q1.delete();
      end else begin
         if (ohs0) void'(exp_q0.pop_front());
         if (ohs1) void'(exp_q1.pop_front());
         if (ihs0) exp_q0.push_back(in_data);
         if (ihs1) exp_q1.push_back(in_data);
      end
   end

   // ---------------------------------------------------------------- scoreboard
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m0_out_valid", W'(out_valid0), W'(exp_q0.size() != 0));
         chk("m0_out_data",  out_data0, (exp_q0.size() != 0) ? exp_q0[0] : IFID_BUBBLE);
         chk("m0_occ",       W'(occ0), W'(exp_q0.size()));
         chk("m0_in_ready",  W'(in_ready0), W'((exp_q0.size() == 0) || out_ready));
         chk("m0_consumed",  W'(dut_cons0), W'(cons0));
         chk("m1_out_valid", W'(out_valid1), W'(exp_q1.size() != 0));
         chk("m1_out_data",  out_data1, (exp_q1.size() != 0) ? exp_q1[0] : IFID_BUBBLE);
         chk("m1_occ",       W'(occ1), W'(exp_q1.size()));
         chk("m1_in_ready",  W'(in_ready1), W'(exp_q1.size() < 2));
         chk("m1_consumed",  W'(dut_cons1), W'(cons1));
         // count handshakes that will complete at the coming edge
         if (out_valid0 && out_ready) dut_cons0++;
         if (out_valid1 && out_ready) dut_cons1++;
      end
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      int c0, c1;

      // Reset for two cycles with a beat offered and downstream stalled
      in_data = mk(32'h900);
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      settle();
      chk("rst_m0_valid", W'(out_valid0), W'(0));
      chk("rst_m0_data",  out_data0, IFID_BUBBLE);
      chk("rst_m0_occ",   W'(occ0), W'(0));
      chk("rst_m0_ready", W'(in_ready0), W'(1));
      chk("rst_m1_valid", W'(out_valid1), W'(0));
      chk("rst_m1_data",  out_data1, IFID_BUBBLE);
      chk("rst_m1_occ",   W'(occ1), W'(0));
      chk("rst_m1_ready", W'(in_ready1), W'(1));

      // Streaming 0x100, 0x104, 0x108 back to back
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_data = mk(32'h100);
      tick();
      in_data = mk(32'h104);
      settle();
      chk("str_m0_b0", out_data0, mk(32'h100));
      chk("str_m1_b0", out_data1, mk(32'h100));
      tick();
      in_data = mk(32'h108);
      settle();
      chk("str_m0_b1", out_data0, mk(32'h104));
      chk("str_m1_b1", out_data1, mk(32'h104));
      tick();
      in_valid = 1'b0;
      settle();
      chk("str_m0_b2", out_data0, mk(32'h108));
      chk("str_m1_b2", out_data1, mk(32'h108));
      chk("str_m1_v2", W'(out_valid1), W'(1));
      tick();
      settle();
      chk("str_m0_done", W'(out_valid0), W'(0));
      chk("str_m1_done", W'(out_valid1), W'(0));

      // Stall: 0x100 then 0x104 with downstream held off
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = mk(32'h100);
      tick();
      in_data = mk(32'h104);
      settle();
      chk("stl_m0_ready_same_cycle", W'(in_ready0), W'(0));
      chk("stl_m1_ready_one", W'(in_ready1), W'(1));
      tick();
      in_data = mk(32'h108);
      settle();
      chk("stl_m1_occ2",  W'(occ1), W'(2));
      chk("stl_m1_ready", W'(in_ready1), W'(0));
      chk("stl_m1_head",  out_data1, mk(32'h100));
      chk("stl_m0_head",  out_data0, mk(32'h100));
      chk("stl_model_q1", W'(exp_q1.size()), W'(2));
      tick();
      settle();
      chk("stl_m1_hold",  out_data1, mk(32'h100));
      chk("stl_m0_hold",  out_data0, mk(32'h100));
      out_ready = 1'b1;
      in_valid = 1'b0;
      tick();
      settle();
      chk("rel_m1_b1",     out_data1, mk(32'h104));
      chk("rel_m1_ready",  W'(in_ready1), W'(1));
      chk("rel_m1_occ",    W'(occ1), W'(1));
      chk("rel_m0_empty",  W'(out_valid0), W'(0));
      tick();
      settle();
      chk("rel_m1_empty",  W'(out_valid1), W'(0));

      // Flush with both entries full and a new beat offered
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = mk(32'h200);
      tick();
      in_data = mk(32'h204);
      tick();
      in_data = mk(32'h208);
      flush = 1'b1;
      settle();
      chk("fl_m1_full", W'(occ1), W'(2));
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      settle();
      chk("fl_m0_valid", W'(out_valid0), W'(0));
      chk("fl_m0_data",  out_data0, IFID_BUBBLE);
      chk("fl_m0_occ",   W'(occ0), W'(0));
      chk("fl_m1_valid", W'(out_valid1), W'(0));
      chk("fl_m1_data",  out_data1, IFID_BUBBLE);
      chk("fl_m1_occ",   W'(occ1), W'(0));
      chk("fl_m1_ready", W'(in_ready1), W'(1));
      out_ready = 1'b1;
      tick();
      tick();
      settle();
      chk("fl_m0_no208", W'(out_valid0), W'(0));
      chk("fl_m1_no208", W'(out_valid1), W'(0));

      // Flush together with an output handshake: beat consumed exactly once
      in_valid = 1'b1;
      in_data = mk(32'h300);
      tick();
      in_valid = 1'b0;
      settle();
      chk("sim_m0_head", out_data0, mk(32'h300));
      chk("sim_m1_head", out_data1, mk(32'h300));
      c0 = dut_cons0;
      c1 = dut_cons1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      settle();
      chk("sim_m0_cons_once", W'(dut_cons0 - c0), W'(1));
      chk("sim_m1_cons_once", W'(dut_cons1 - c1), W'(1));
      chk("sim_m0_empty", W'(out_valid0), W'(0));
      chk("sim_m1_empty", W'(occ1), W'(0));
      tick();
      settle();
      chk("sim_m1_still_empty", W'(out_valid1), W'(0));

      // Reset and flush together mid-stream with skid full
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = mk(32'h400);
      tick();
      in_data = mk(32'h404);
      tick();
      rst = 1'b1;
      flush = 1'b1;
      tick();
      rst = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      settle();
      chk("rf_m0_valid", W'(out_valid0), W'(0));
      chk("rf_m1_occ",   W'(occ1), W'(0));
      chk("rf_m1_data",  out_data1, IFID_BUBBLE);
      chk("rf_m1_ready", W'(in_ready1), W'(1));
      out_ready = 1'b1;
      tick();
      tick();
      settle();
      chk("rf_m1_no_beat", W'(out_valid1), W'(0));

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
